// File: rtl/decoder_pkg.sv
// Shared decoder/CSR types, plus the CSR port arbiter's state and request types.
package decoder_pkg;

    typedef logic [11:0] CsrAddrT;
    typedef logic [31:0] word;
    typedef logic [4:0]  r;

    typedef enum logic [2:0] {
        ECALL  = 3'd0,
        CSRRW  = 3'd1,
        CSRRS  = 3'd2,
        CSRRC  = 3'd3,
        EBREAK = 3'd4,
        CSRRWI = 3'd5,
        CSRRSI = 3'd6,
        CSRRCI = 3'd7
    } csr_op_t;

    typedef enum logic [1:0] {
        IDLE,
        PEND,
        RSP
    } arb_state_t;

    typedef struct packed {
        CsrAddrT addr;
        csr_op_t op;
        word     data;
    } ext_req_t;

    // Anything that is not a real CSR access becomes a side-effect-free read.
    function automatic ext_req_t sanitize_req(CsrAddrT addr, csr_op_t op, word data);
        ext_req_t req;
        req.addr = addr;
        case (op)
            CSRRW, CSRRS, CSRRC, CSRRWI, CSRRSI, CSRRCI: begin
                req.op   = op;
                req.data = data;
            end
            default: begin
                req.op   = CSRRS;
                req.data = '0;
            end
        endcase
        return req;
    endfunction

endpackage

// File: rtl/csr_arbiter.sv
// Shares the CSR file port between the core (priority) and an external requester.
// Optional starvation guard: define CSR_ARB_STARVE_EN.
module csr_arbiter
    import decoder_pkg::*;
#(
    parameter int unsigned StarveLimit = 8,
    parameter int unsigned CntWidth    = $clog2(StarveLimit + 1)
) (
    input  logic    clk,
    input  logic    reset,
    input  logic    core_csr_enable,
    input  CsrAddrT core_csr_addr,
    input  csr_op_t core_csr_op,
    input  word     core_rs1_data,
    input  r        core_rs1_zimm,
    output logic    core_stall,
    input  logic    ext_req_valid,
    output logic    ext_req_ready,
    input  CsrAddrT ext_req_addr,
    input  csr_op_t ext_req_op,
    input  word     ext_req_data,
    output logic    ext_rsp_valid,
    output word     ext_rsp_data,
    input  logic    ext_rsp_ready,
    output logic    csr_enable,
    output CsrAddrT csr_addr,
    output csr_op_t csr_op,
    output word     csr_rs1_data,
    output r        csr_rs1_zimm,
    input  word     csr_out,
    output logic    ext_grant
);

    arb_state_t state_q, state_d;
    ext_req_t   req_q;
    word        rsp_data_q;
    logic       issue;
    logic       forced;

`ifdef CSR_ARB_STARVE_EN
    logic [CntWidth-1:0] starve_q;

    assign forced = (state_q == PEND) && (starve_q == CntWidth'(StarveLimit));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            starve_q <= '0;
        end else if (issue) begin
            starve_q <= '0;
        end else if (state_q == PEND && core_csr_enable
                     && starve_q != CntWidth'(StarveLimit)) begin
            starve_q <= starve_q + 1'b1;
        end
    end
`else
    assign forced = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            req_q      <= '0;
            rsp_data_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && ext_req_valid) begin
                req_q <= sanitize_req(ext_req_addr, ext_req_op, ext_req_data);
            end
            if (issue) begin
                rsp_data_q <= csr_out;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        issue   = 1'b0;
        case (state_q)
            IDLE: begin
                if (ext_req_valid) begin
                    state_d = PEND;
                end
            end
            PEND: begin
                if (!core_csr_enable || forced) begin
                    issue   = 1'b1;
                    state_d = RSP;
                end
            end
            RSP: begin
                if (ext_rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The read value is taken in the same cycle the write commits, so it is the pre-write value.
    always_comb begin
        ext_req_ready = (state_q == IDLE);
        ext_rsp_valid = (state_q == RSP);
        ext_rsp_data  = rsp_data_q;
        ext_grant     = issue;
        core_stall    = issue && core_csr_enable;
        if (issue) begin
            csr_enable   = reset;
            csr_addr     = req_q.addr;
            csr_op       = req_q.op;
            csr_rs1_data = req_q.data;
            csr_rs1_zimm = req_q.data[4:0];
        end else begin
            csr_enable   = reset && core_csr_enable;
            csr_addr     = core_csr_addr;
            csr_op       = core_csr_op;
            csr_rs1_data = core_rs1_data;
            csr_rs1_zimm = core_rs1_zimm;
        end
    end

endmodule

// File: tb/tb_csr_arbiter.sv
// Self-checking bench for csr_arbiter with a small behavioural CSR file behind it.
module tb_csr_arbiter;
    import decoder_pkg::*;

    logic    clk = 1'b0;
    logic    reset;
    logic    core_csr_enable;
    CsrAddrT core_csr_addr;
    csr_op_t core_csr_op;
    word     core_rs1_data;
    r        core_rs1_zimm;
    logic    core_stall;
    logic    ext_req_valid;
    logic    ext_req_ready;
    CsrAddrT ext_req_addr;
    csr_op_t ext_req_op;
    word     ext_req_data;
    logic    ext_rsp_valid;
    word     ext_rsp_data;
    logic    ext_rsp_ready;
    logic    csr_enable;
    CsrAddrT csr_addr;
    csr_op_t csr_op;
    word     csr_rs1_data;
    r        csr_rs1_zimm;
    word     csr_out;
    logic    ext_grant;

    int unsigned vec  = 0;
    int unsigned errs = 0;
    word sb[$];
    word csr_mem [4];

    always #5 clk = ~clk;

    csr_arbiter #(.StarveLimit(8)) dut (
        .clk(clk), .reset(reset),
        .core_csr_enable(core_csr_enable), .core_csr_addr(core_csr_addr),
        .core_csr_op(core_csr_op), .core_rs1_data(core_rs1_data),
        .core_rs1_zimm(core_rs1_zimm), .core_stall(core_stall),
        .ext_req_valid(ext_req_valid), .ext_req_ready(ext_req_ready),
        .ext_req_addr(ext_req_addr), .ext_req_op(ext_req_op),
        .ext_req_data(ext_req_data), .ext_rsp_valid(ext_rsp_valid),
        .ext_rsp_data(ext_rsp_data), .ext_rsp_ready(ext_rsp_ready),
        .csr_enable(csr_enable), .csr_addr(csr_addr), .csr_op(csr_op),
        .csr_rs1_data(csr_rs1_data), .csr_rs1_zimm(csr_rs1_zimm),
        .csr_out(csr_out), .ext_grant(ext_grant)
    );

    function automatic word csr_next(word old, csr_op_t op, word rs1, r zimm);
        logic [2:0] o;
        word operand;
        o = op;
        operand = o[2] ? {27'b0, zimm} : rs1;
        case (o[1:0])
            2'b01:   return operand;
            2'b10:   return old | operand;
            2'b11:   return old & ~operand;
            default: return old;
        endcase
    endfunction

    assign csr_out = csr_mem[csr_addr[1:0]];

    always @(posedge clk) begin
        if (csr_enable) begin
            csr_mem[csr_addr[1:0]] <= csr_next(csr_mem[csr_addr[1:0]], csr_op,
                                               csr_rs1_data, csr_rs1_zimm);
        end
    end

    task automatic core_write(input logic [1:0] a, input word v);
        @(negedge clk);
        core_csr_enable = 1'b1;
        core_csr_addr   = {10'b0, a};
        core_csr_op     = CSRRW;
        core_rs1_data   = v;
        core_rs1_zimm   = '0;
        @(negedge clk);
        core_csr_enable = 1'b0;
    endtask

    // Waits for the response, holds off ready for 'hold' cycles, then pops and compares.
    task automatic collect_rsp(input int unsigned hold, input string name);
        word exp;
        int unsigned n = 0;
        while (!ext_rsp_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        vec++;
        if (!ext_rsp_valid) begin
            errs++;
            $display("FAIL %s rsp_timeout: ext_rsp_valid=%b after %0d cycles, required 1", name, ext_rsp_valid, n);
            return;
        end
        exp = sb.pop_front();
        for (int unsigned h = 0; h < hold; h++) begin
            vec++;
            if (ext_rsp_valid !== 1'b1 || ext_rsp_data !== exp || ext_req_ready !== 1'b0) begin
                errs++;
                $display("FAIL %s hold[%0d]: valid=%b data=%h ready=%b, required 1 %h 0",
                         name, h, ext_rsp_valid, ext_rsp_data, ext_req_ready, exp);
            end
            @(negedge clk);
        end
        vec++;
        if (ext_rsp_data !== exp) begin
            errs++;
            $display("FAIL %s rsp_data: got %h, required %h", name, ext_rsp_data, exp);
        end
        ext_rsp_ready = 1'b1;
        @(negedge clk);
        ext_rsp_ready = 1'b0;
        vec++;
        if (ext_rsp_valid !== 1'b0 || ext_req_ready !== 1'b1) begin
            errs++;
            $display("FAIL %s rsp_done: valid=%b req_ready=%b, required 0 1", name, ext_rsp_valid, ext_req_ready);
        end
    endtask

    // Accepts one request with the core idle; checks one-cycle issue and the issued bus values.
    task automatic ext_access(input logic [1:0] a, input csr_op_t op, input word d, input word exp_old,
                              input csr_op_t iss_op, input word iss_rs1, input int unsigned hold,
                              input string name);
        @(negedge clk);
        ext_req_valid = 1'b1;
        ext_req_addr  = {10'b0, a};
        ext_req_op    = op;
        ext_req_data  = d;
        #1;
        vec++;
        if (ext_req_ready !== 1'b1) begin
            errs++;
            $display("FAIL %s accept: ext_req_ready=%b, required 1", name, ext_req_ready);
        end
        sb.push_back(exp_old);
        @(negedge clk);
        ext_req_valid = 1'b0;
        #1;
        vec++;
        if (ext_grant !== 1'b1 || csr_enable !== 1'b1 || csr_addr !== {10'b0, a}
            || csr_op !== iss_op || csr_rs1_data !== iss_rs1 || csr_rs1_zimm !== iss_rs1[4:0]) begin
            errs++;
            $display("FAIL %s issue: grant=%b en=%b addr=%h op=%0d rs1=%h zimm=%h, required 1 1 %h %0d %h %h",
                     name, ext_grant, csr_enable, csr_addr, csr_op, csr_rs1_data, csr_rs1_zimm,
                     {10'b0, a}, iss_op, iss_rs1, iss_rs1[4:0]);
        end
        @(negedge clk);
        collect_rsp(hold, name);
    endtask

    task automatic test_reset;
        reset           = 1'b0;
        core_csr_enable = 1'b1;
        core_csr_addr   = '0;
        core_csr_op     = CSRRS;
        core_rs1_data   = '0;
        core_rs1_zimm   = '0;
        ext_req_valid   = 1'b0;
        ext_req_addr    = '0;
        ext_req_op      = CSRRS;
        ext_req_data    = '0;
        ext_rsp_ready   = 1'b0;
        repeat (2) @(negedge clk);
        vec++;
        if (ext_rsp_valid !== 1'b0 || ext_rsp_data !== '0 || ext_grant !== 1'b0
            || core_stall !== 1'b0 || csr_enable !== 1'b0) begin
            errs++;
            $display("FAIL reset_values: valid=%b data=%h grant=%b stall=%b en=%b, required 0 0 0 0 0",
                     ext_rsp_valid, ext_rsp_data, ext_grant, core_stall, csr_enable);
        end
        core_csr_enable = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        vec++;
        if (ext_req_ready !== 1'b1) begin
            errs++;
            $display("FAIL reset_ready: ext_req_ready=%b, required 1", ext_req_ready);
        end
    endtask

    task automatic test_idle_bus;
        @(negedge clk);
        core_csr_enable = 1'b1;
        core_csr_addr   = '0;
        core_csr_op     = CSRRW;
        core_rs1_data   = 32'b1011;
        core_rs1_zimm   = 5'd7;
        #1;
        vec++;
        if (csr_enable !== 1'b1 || csr_addr !== '0 || csr_op !== CSRRW || csr_rs1_data !== 32'b1011
            || csr_rs1_zimm !== 5'd7 || core_stall !== 1'b0 || ext_grant !== 1'b0) begin
            errs++;
            $display("FAIL idle_mirror: en=%b addr=%h op=%0d rs1=%h zimm=%h stall=%b grant=%b",
                     csr_enable, csr_addr, csr_op, csr_rs1_data, csr_rs1_zimm, core_stall, ext_grant);
        end
        @(negedge clk);
        core_csr_enable = 1'b0;
        vec++;
        if (csr_mem[0] !== 32'b1011) begin
            errs++;
            $display("FAIL idle_write: csr[0]=%h, required %h", csr_mem[0], 32'b1011);
        end
    endtask

    task automatic test_ext_read;
        ext_access(2'd0, CSRRS, 32'd0, 32'b1011, CSRRS, 32'd0, 0, "ext_read");
        vec++;
        if (csr_mem[0] !== 32'b1011) begin
            errs++;
            $display("FAIL ext_read_unchanged: csr[0]=%h, required %h", csr_mem[0], 32'b1011);
        end
    endtask

    task automatic test_collision;
        int unsigned grants = 0, stalls = 0, grant_at = 99;
        core_write(2'd1, 32'h5A);
        @(negedge clk);
        ext_req_valid = 1'b1;
        ext_req_addr  = 12'd1;
        ext_req_op    = CSRRS;
        ext_req_data  = '0;
        sb.push_back(32'h5A);
        @(negedge clk);
        ext_req_valid   = 1'b0;
        core_csr_enable = 1'b1;
        core_csr_addr   = 12'd1;
        core_csr_op     = CSRRS;
        core_rs1_data   = '0;
        for (int unsigned c = 0; c < 20; c++) begin
            #1;
            if (ext_grant) begin
                grants++;
                grant_at = c;
            end
            if (core_stall) stalls++;
            @(negedge clk);
        end
        core_csr_enable = 1'b0;
`ifdef CSR_ARB_STARVE_EN
        vec++;
        if (grants != 1 || stalls != 1 || grant_at != 8) begin
            errs++;
            $display("FAIL collision_forced: grants=%0d stalls=%0d at=%0d, required 1 1 8", grants, stalls, grant_at);
        end
`else
        vec++;
        if (grants != 0 || stalls != 0) begin
            errs++;
            $display("FAIL collision_strict: grants=%0d stalls=%0d, required 0 0", grants, stalls);
        end
`endif
        collect_rsp(0, "collision");
    endtask

    task automatic test_ext_write;
        core_write(2'd2, 32'b0011);
        ext_access(2'd2, CSRRC, 32'b0001, 32'b0011, CSRRC, 32'b0001, 0, "ext_write");
        vec++;
        if (csr_mem[2] !== 32'b0010) begin
            errs++;
            $display("FAIL ext_write_commit: csr[2]=%h, required %h", csr_mem[2], 32'b0010);
        end
        core_write(2'd3, 32'd0);
        ext_access(2'd3, CSRRSI, 32'hFFFF_FFE4, 32'd0, CSRRSI, 32'hFFFF_FFE4, 0, "ext_imm");
        vec++;
        if (csr_mem[3] !== 32'd4) begin
            errs++;
            $display("FAIL ext_imm_commit: csr[3]=%h, required %h", csr_mem[3], 32'd4);
        end
    endtask

    task automatic test_backpressure;
        ext_access(2'd2, CSRRS, 32'd0, 32'b0010, CSRRS, 32'd0, 5, "backpressure");
        ext_access(2'd2, ECALL, 32'hFFFF_FFFF, 32'b0010, CSRRS, 32'd0, 0, "sanitize");
        vec++;
        if (csr_mem[2] !== 32'b0010) begin
            errs++;
            $display("FAIL sanitize_unchanged: csr[2]=%h, required %h", csr_mem[2], 32'b0010);
        end
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        ext_req_valid = 1'b1;
        ext_req_addr  = 12'd0;
        ext_req_op    = CSRRS;
        ext_req_data  = '0;
        @(negedge clk);
        ext_req_valid = 1'b0;
        @(negedge clk);
        vec++;
        if (ext_rsp_valid !== 1'b1) begin
            errs++;
            $display("FAIL mid_reach_rsp: ext_rsp_valid=%b, required 1", ext_rsp_valid);
        end
        core_csr_enable = 1'b1;
        #2 reset = 1'b0;
        #1;
        vec++;
        if (ext_rsp_valid !== 1'b0 || csr_enable !== 1'b0 || ext_grant !== 1'b0) begin
            errs++;
            $display("FAIL mid_reset_async: valid=%b en=%b grant=%b, required 0 0 0", ext_rsp_valid, csr_enable, ext_grant);
        end
        @(negedge clk);
        core_csr_enable = 1'b0;
        reset = 1'b1;
        for (int unsigned c = 0; c < 3; c++) begin
            @(negedge clk);
            vec++;
            if (ext_req_ready !== 1'b1 || ext_rsp_valid !== 1'b0 || ext_rsp_data !== '0) begin
                errs++;
                $display("FAIL mid_after_release[%0d]: ready=%b valid=%b data=%h, required 1 0 0",
                         c, ext_req_ready, ext_rsp_valid, ext_rsp_data);
            end
        end
    endtask

    initial begin
        test_reset();
        test_idle_bus();
        test_ext_read();
        test_collision();
        test_ext_write();
        test_backpressure();
        test_reset_mid();
        vec++;
        if (sb.size() != 0) begin
            errs++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
